gray_counter_param: RTL
=======================

// Module: gray_counter_param
// PURPOSE
//  - Parametrised N-bit Gray-code counter; successor to the fixed 3-bit Gray sequencer.
//  - Adds up/down counting, enable, synchronous clear and parallel load.
//  - Provides a wrap-ahead terminal-count flag and a registered wrap pulse.
//  - Gray output drives CDC pointer/sequencer logic; binary output feeds local arithmetic.
// PARAMETERS
//  - WIDTH     3   counter width in bits, >= 2; period is 2**WIDTH states
//  - RST_BIN   0   binary reset/clear value; Gray form is applied on reset
// PORTS
//  - clk        in   1      rising-edge clock
//  - rst_n      in   1      asynchronous active-low reset
//  - en_i       in   1      advance one step this cycle
//  - up_i       in   1      1 = count up, 0 = count down; sampled with en_i
//  - clr_i      in   1      synchronous clear to RST_BIN
//  - load_i     in   1      synchronous load from load_bin_i
//  - load_bin_i in   WIDTH  binary load value, converted to Gray internally
//  - gray_o     out  WIDTH  registered Gray count
//  - bin_o      out  WIDTH  binary equivalent of gray_o (combinational decode)
//  - tc_o       out  1      combinational: en_i=1 and next edge wraps
//  - wrap_o     out  1      registered one-cycle pulse after a wrap occurred
//  - err_o      out  1      sticky step error (only with GRAY_CNT_ERRCHK_EN)
// BEHAVIOUR
//  - State is one WIDTH-bit register gray_q; gray_o = gray_q.
//  - Decode: bin[W-1] = g[W-1]; bin[i] = bin[i+1] ^ g[i].
//  - Encode: g = b ^ (b >> 1).
//  - Reset (rst_n=0, async): gray_q = bin2gray(RST_BIN), wrap_o = 0, err_o = 0.
//    Takes effect immediately, including mid-count.
//  - Per-edge priority: clr_i > load_i > en_i > hold.
//    - clr_i:  gray_q <= bin2gray(RST_BIN).
//    - load_i: gray_q <= bin2gray(load_bin_i).
//    - en_i:   gray_q <= bin2gray(bin_o +/- 1), modulo 2**WIDTH.
//    - en_i=0: hold; up_i is ignored.
//  - Arithmetic is WIDTH-bit, unsigned, wrapping.
//    - Up from 2**W-1 gives 0; down from 0 gives 2**W-1.
//  - Any enabled step changes exactly one bit of gray_q, including at the wrap.
//  - tc_o = en_i & ~clr_i & ~load_i & (up_i ? bin_o == 2**W-1 : bin_o == 0).
//  - wrap_o <= tc_o each edge, so the pulse is high the cycle after the wrap.
//  - wrap_o is never set by clr_i or load_i, even when they move the count across zero.
//  - Direction change: takes effect on the very next enabled edge; no dead cycle.
//  - clr_i and load_i asserted together: clr_i wins; load_bin_i is ignored.
//  - Latency: gray_o updates 1 cycle after the control input; bin_o follows in the same cycle.
// CONFIGURATION
//  - Macro: GRAY_CNT_ERRCHK_EN.
//  - Defined:
//    - Registers the previous gray_q.
//    - If an enabled step (not clr/load, not the first cycle after reset) changes
//      other than exactly one bit, err_o is set.
//    - err_o stays high until rst_n is asserted.
//  - Undefined: no checker logic; err_o is tied to 0.
// TESTING
//  - Default WIDTH=3.
//  - Reset then en_i=1, up_i=1 for 9 cycles
//    -> gray_o 000,001,011,010,110,111,101,100,000.
//    -> tc_o high in the cycle gray_o=100; wrap_o high the following cycle only.
//  - From gray 000, en_i=1, up_i=0
//    -> gray_o 100,101,111; tc_o high in the cycle gray_o=000.
//  - load_i=1 with load_bin_i=5 -> next cycle gray_o=111, bin_o=5.
//  - clr_i=1 with load_i=1 and en_i=1 -> gray_o=000, wrap_o stays 0.
//  - rst_n pulled low mid-count (gray_o=110), asynchronously, not on a clock edge
//    -> gray_o=000 before the next clk edge; counting resumes at 001 after release.
//  - WIDTH=8, full up and down sweeps
//    -> every step has Hamming distance 1; one wrap_o per 256 steps.
//    -> With GRAY_CNT_ERRCHK_EN, err_o stays 0.

Source files
------------

// File: rtl/gray_counter_param_if.sv
// Control and status bundle for gray_counter_param; WIDTH must match the counter instance.
interface gray_counter_param_if #(
  parameter int WIDTH = 3
);
  logic             en_i;
  logic             up_i;
  logic             clr_i;
  logic             load_i;
  logic [WIDTH-1:0] load_bin_i;
  logic [WIDTH-1:0] gray_o;
  logic [WIDTH-1:0] bin_o;
  logic             tc_o;
  logic             wrap_o;
  logic             err_o;

  modport master (
    output en_i, up_i, clr_i, load_i, load_bin_i,
    input  gray_o, bin_o, tc_o, wrap_o, err_o
  );

  modport slave (
    input  en_i, up_i, clr_i, load_i, load_bin_i,
    output gray_o, bin_o, tc_o, wrap_o, err_o
  );
endinterface

// File: rtl/gray_counter_param.sv
// Parametrised up/down Gray counter with clear, load, terminal-count and wrap pulse.
// Optional single-bit-step checker enabled by defining GRAY_CNT_ERRCHK_EN.
module gray_counter_param #(
  parameter int WIDTH   = 3,
  parameter int RST_BIN = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  gray_counter_param_if.slave bus
);
  typedef logic [WIDTH-1:0] word_t;

  function automatic word_t bin2gray(word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic word_t gray2bin(word_t g);
    word_t b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  localparam word_t RST_GRAY = bin2gray(word_t'(RST_BIN));

  word_t gray_q;
  word_t gray_d;
  word_t bin;
  logic  step;
  logic  tc;
  logic  wrap_q;

  assign bin  = gray2bin(gray_q);
  assign step = bus.en_i & ~bus.clr_i & ~bus.load_i;
  // Terminal count looks ahead: high while the coming edge will wrap.
  assign tc   = step & (bus.up_i ? (bin == '1) : (bin == '0));

  // NOTE: default assigned first so every path drives gray_d and no latch is inferred.
  always_comb begin
    gray_d = gray_q;
    if (bus.clr_i)       gray_d = RST_GRAY;
    else if (bus.load_i) gray_d = bin2gray(bus.load_bin_i);
    else if (bus.en_i)   gray_d = bin2gray(bus.up_i ? bin + word_t'(1) : bin - word_t'(1));
  end

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_q <= RST_GRAY;
      wrap_q <= 1'b0;
    end else begin
      gray_q <= gray_d;
      wrap_q <= tc;
    end
  end

  assign bus.gray_o = gray_q;
  assign bus.bin_o  = bin;
  assign bus.tc_o   = tc;
  assign bus.wrap_o = wrap_q;

`ifdef GRAY_CNT_ERRCHK_EN
  function automatic int unsigned ones(word_t v);
    int unsigned n = 0;
    for (int i = 0; i < WIDTH; i++) n = n + 32'(v[i]);
    return n;
  endfunction

  word_t prev_q;
  logic  chk_q;
  logic  err_q;

  // chk_q marks that the last edge was a counting step, so the pair (prev_q, gray_q)
  // must differ in exactly one bit; clear, load and the first cycle after reset are exempt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= RST_GRAY;
      chk_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= gray_q;
      chk_q  <= step;
      if (chk_q && (ones(gray_q ^ prev_q) != 1)) err_q <= 1'b1;
    end
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

endmodule
